// File: rtl/spi_master_arb_if.sv
// Bus bundle for spi_master_arb: requester handshake, transfer mode and SPI pins.
// The master modport is the arbiter/SPI engine view; slave is the client/pad view.
interface spi_master_arb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2
);
    logic                            CPOL;
    logic                            CPHA;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*DATA_WIDTH-1:0]   datai;
    logic [NUM_REQ-1:0]              gnt;
    logic [NUM_REQ-1:0]              done;
    logic [DATA_WIDTH-1:0]           datao;
    logic                            busy;
    logic                            sclk;
    logic                            csb;
    logic                            dout;
    logic                            din;

    modport master (
        input  CPOL, CPHA, req, datai, din,
        output gnt, done, datao, busy, sclk, csb, dout
    );

    modport slave (
        output CPOL, CPHA, req, datai, din,
        input  gnt, done, datao, busy, sclk, csb, dout
    );
endinterface

// File: rtl/spi_master_arb.sv
// Round-robin arbitrated SPI master: grants one requester at a time and runs a
// single MSB-first full-duplex transfer in the CPOL/CPHA mode latched at grant.
module spi_master_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              clk,
    input  logic              resetb,
    spi_master_arb_if.master  bus
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]   DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [EDGE_W-1:0]  EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                state_r,  state_s;
    logic [CNT_W-1:0]      cnt_r,    cnt_s;
    logic [EDGE_W-1:0]     edge_r,   edge_s;
    logic [PTR_W-1:0]      ptr_r,    ptr_s;
    logic [PTR_W-1:0]      owner_r,  owner_s;
    logic                  cpol_r,   cpol_s;
    logic                  cpha_r,   cpha_s;
    logic [DATA_WIDTH-1:0] tx_r,     tx_s;
    logic [DATA_WIDTH-1:0] rx_r,     rx_s;
    logic [NUM_REQ-1:0]    gnt_r,    gnt_s;
    logic [NUM_REQ-1:0]    done_r,   done_s;
    logic [DATA_WIDTH-1:0] datao_r,  datao_s;
    logic                  busy_r,   busy_s;
    logic                  sclk_r,   sclk_s;
    logic                  csb_r,    csb_s;
    logic                  dout_r,   dout_s;

    logic                  found_s;
    logic [PTR_W-1:0]      pick_s;
    logic [DATA_WIDTH-1:0] pick_data_s;

    // Round-robin pick: first requester at or above the pointer, else wrap to the lowest.
    always_comb begin
        found_s     = 1'b0;
        pick_s      = '0;
        pick_data_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_s && bus.req[j] && (PTR_W'(j) >= ptr_r)) begin
                found_s     = 1'b1;
                pick_s      = PTR_W'(j);
                pick_data_s = bus.datai[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                found_s     = found_s;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_s && bus.req[j]) begin
                found_s     = 1'b1;
                pick_s      = PTR_W'(j);
                pick_data_s = bus.datai[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        edge_s  = edge_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        cpol_s  = cpol_r;
        cpha_s  = cpha_r;
        tx_s    = tx_r;
        rx_s    = rx_r;
        gnt_s   = gnt_r;
        done_s  = '0;
        datao_s = datao_r;
        sclk_s  = sclk_r;
        csb_s   = csb_r;
        dout_s  = dout_r;
        case (state_r)
            ST_IDLE: begin
                sclk_s = bus.CPOL;
                if (found_s) begin
                    owner_s = pick_s;
                    gnt_s   = GNT_ONE << pick_s;
                    tx_s    = pick_data_s;
                    rx_s    = '0;
                    cpol_s  = bus.CPOL;
                    cpha_s  = bus.CPHA;
                    csb_s   = 1'b0;
                    dout_s  = pick_data_s[DATA_WIDTH-1];
                    cnt_s   = '0;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s   = '0;
                    edge_s  = '0;
                    state_s = ST_SHIFT;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s  = '0;
                    sclk_s = ~sclk_r;
                    edge_s = edge_r + EDGE_W'(1);
                    // edge_r even means this toggle is a leading (odd-numbered) edge
                    if (!edge_r[0]) begin
                        if (cpha_r) begin
                            dout_s = tx_r[DATA_WIDTH-1];
                            tx_s   = {tx_r[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            rx_s   = {rx_r[DATA_WIDTH-2:0], bus.din};
                        end
                    end else begin
                        if (cpha_r) begin
                            rx_s   = {rx_r[DATA_WIDTH-2:0], bus.din};
                        end else if (edge_r != EDGE_LAST) begin
                            dout_s = tx_r[DATA_WIDTH-2];
                            tx_s   = {tx_r[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            dout_s = dout_r;
                        end
                    end
                    if (edge_r == EDGE_LAST) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s   = '0;
                    csb_s   = 1'b1;
                    datao_s = rx_r;
                    done_s  = gnt_r;
                    gnt_s   = '0;
                    ptr_s   = (owner_r == PTR_LAST) ? PTR_W'(0) : owner_r + PTR_W'(1);
                    state_s = ST_GAP;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s   = '0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset aborts any transfer without a done pulse.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            edge_r  <= '0;
            ptr_r   <= '0;
            owner_r <= '0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            tx_r    <= '0;
            rx_r    <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            datao_r <= '0;
            busy_r  <= 1'b0;
            sclk_r  <= 1'b0;
            csb_r   <= 1'b1;
            dout_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            edge_r  <= edge_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
            cpol_r  <= cpol_s;
            cpha_r  <= cpha_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            datao_r <= datao_s;
            busy_r  <= busy_s;
            sclk_r  <= sclk_s;
            csb_r   <= csb_s;
            dout_r  <= dout_s;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.done  = done_r;
    assign bus.datao = datao_r;
    assign bus.busy  = busy_r;
    assign bus.sclk  = sclk_r;
    assign bus.csb   = csb_r;
    assign bus.dout  = dout_r;
endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench for spi_master_arb: a behavioural SPI slave sits on the bus,
// a monitor pops expected words on every done pulse. Two DUTs: CLK_DIV=2 and CLK_DIV=1.
module tb_spi_master_arb;
    logic clk;
    logic resetb;
    logic sel;

    spi_master_arb_if #(.DATA_WIDTH(16), .NUM_REQ(2)) bus_a ();
    spi_master_arb_if #(.DATA_WIDTH(16), .NUM_REQ(2)) bus_f ();

    spi_master_arb #(.DATA_WIDTH(16), .NUM_REQ(2), .CLK_DIV(2), .CS_GAP(2)) dut_a (
        .clk(clk), .resetb(resetb), .bus(bus_a.master));
    spi_master_arb #(.DATA_WIDTH(16), .NUM_REQ(2), .CLK_DIV(1), .CS_GAP(2)) dut_f (
        .clk(clk), .resetb(resetb), .bus(bus_f.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus seen by the slave model and the monitor
    logic        miso;
    logic        s_sclk, s_csb, s_mosi;
    logic [1:0]  s_gnt, s_done;
    logic [15:0] s_datao;
    assign s_sclk  = sel ? bus_f.sclk  : bus_a.sclk;
    assign s_csb   = sel ? bus_f.csb   : bus_a.csb;
    assign s_mosi  = sel ? bus_f.dout  : bus_a.dout;
    assign s_gnt   = sel ? bus_f.gnt   : bus_a.gnt;
    assign s_done  = sel ? bus_f.done  : bus_a.done;
    assign s_datao = sel ? bus_f.datao : bus_a.datao;
    assign bus_a.din = miso;
    assign bus_f.din = miso;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural SPI slave
    logic [15:0] slave_tx, s_tx, s_rx, slave_rx_word;
    logic        slave_cpha;
    int          s_edges, slave_toggles;

    always @(negedge s_csb) begin
        s_tx    = slave_tx;
        s_rx    = 16'h0000;
        s_edges = 0;
        if (!slave_cpha) begin
            miso = s_tx[15];
            s_tx = {s_tx[14:0], 1'b0};
        end
    end

    always @(s_sclk) begin
        if (s_csb === 1'b0) begin
            s_edges++;
            if ((s_edges % 2) == 1) begin
                if (!slave_cpha) s_rx = {s_rx[14:0], s_mosi};
                else begin miso = s_tx[15]; s_tx = {s_tx[14:0], 1'b0}; end
            end else begin
                if (slave_cpha) s_rx = {s_rx[14:0], s_mosi};
                else begin miso = s_tx[15]; s_tx = {s_tx[14:0], 1'b0}; end
            end
        end
    end

    always @(posedge s_csb) begin
        slave_rx_word = s_rx;
        slave_toggles = s_edges;
    end

    // Scoreboard
    typedef struct {
        logic [1:0]  owner;
        logic [15:0] miso_word;
        logic [15:0] mosi_word;
        int          low;
    } exp_t;
    exp_t sbq[$];

    task automatic push_exp(input logic [1:0] o, input logic [15:0] rxw, input logic [15:0] txw,
                            input int low);
        exp_t e;
        e.owner = o; e.miso_word = rxw; e.mosi_word = txw; e.low = low;
        sbq.push_back(e);
    endtask

    // Monitor: csb timing bookkeeping and comparison on each done pulse
    int         low_cnt, hi_cnt;
    logic       had_xfer;
    logic [1:0] gnt_cap;
    always @(negedge clk) begin
        exp_t e;
        if (!resetb) begin
            low_cnt = 0; hi_cnt = 0; had_xfer = 1'b0;
        end else begin
            if (s_csb == 1'b0) begin
                if (low_cnt == 0) begin
                    gnt_cap = s_gnt;
                    if (had_xfer) chk("cs_gap", 32'(hi_cnt >= 2), 32'd1);
                    hi_cnt = 0;
                end
                low_cnt++;
            end else begin
                hi_cnt++;
            end
            if (s_done != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(s_done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_owner",   32'(s_done),        32'(e.owner));
                    chk("gnt_owner",    32'(gnt_cap),       32'(e.owner));
                    chk("datao",        32'(s_datao),       32'(e.miso_word));
                    chk("slave_rx",     32'(slave_rx_word), 32'(e.mosi_word));
                    chk("sclk_toggles", 32'(slave_toggles), 32'd32);
                    chk("csb_low_clks", 32'(low_cnt),       32'(e.low));
                end
                low_cnt  = 0;
                had_xfer = 1'b1;
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s_done != 2'b00) break;
        end
        chk("done_timeout", 32'(k < 2000), 32'd1);
    endtask

    task automatic wait_csb_low();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_csb == 1'b0) break;
        end
        chk("csb_low_timeout", 32'(k < 200), 32'd1);
    endtask

    // One requester-0 transfer on the selected DUT
    task automatic xfer0(input logic [15:0] mwd, input logic [15:0] swd, input int low);
        slave_tx = swd;
        if (sel) bus_f.datai[15:0] = mwd; else bus_a.datai[15:0] = mwd;
        push_exp(2'b01, swd, mwd, low);
        if (sel) bus_f.req = 2'b01; else bus_a.req = 2'b01;
        wait_done();
        if (sel) bus_f.req = 2'b00; else bus_a.req = 2'b00;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        int k;
        sel = 1'b0; resetb = 1'b1; miso = 1'b0;
        slave_cpha = 1'b0; slave_tx = 16'h5A5A;
        bus_a.CPOL = 1'b0; bus_a.CPHA = 1'b0; bus_a.req = 2'b11;
        bus_a.datai = {16'h2222, 16'h1111};
        bus_f.CPOL = 1'b0; bus_f.CPHA = 1'b0; bus_f.req = 2'b00; bus_f.datai = 32'h0;
        #3 resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_csb",   32'(bus_a.csb),   32'd1);
        chk("rst_sclk",  32'(bus_a.sclk),  32'd0);
        chk("rst_dout",  32'(bus_a.dout),  32'd0);
        chk("rst_gnt",   32'(bus_a.gnt),   32'd0);
        chk("rst_done",  32'(bus_a.done),  32'd0);
        chk("rst_busy",  32'(bus_a.busy),  32'd0);
        chk("rst_datao", 32'(bus_a.datao), 32'd0);

        // Both requesters held from reset: 0, then 1, then 0 again
        push_exp(2'b01, 16'h5A5A, 16'h1111, 68);
        push_exp(2'b10, 16'h5A5A, 16'h2222, 68);
        push_exp(2'b01, 16'h5A5A, 16'h1111, 68);
        resetb = 1'b1;
        wait_done();
        wait_done();
        bus_a.req[1] = 1'b0;
        wait_done();
        bus_a.req[0] = 1'b0;
        repeat (4) @(negedge clk);

        // All four CPOL/CPHA modes
        for (int i = 0; i < 4; i++) begin
            m = 2'(i);
            bus_a.CPOL = m[1]; bus_a.CPHA = m[0]; slave_cpha = m[0];
            repeat (2) @(negedge clk);
            xfer0(16'hA5C3, 16'h3C5A, 68);
            chk("sclk_idle_level", 32'(bus_a.sclk), 32'(m[1]));
        end

        // Requester 1 pulsed for a single cycle
        bus_a.CPOL = 1'b0; bus_a.CPHA = 1'b0; slave_cpha = 1'b0;
        slave_tx = 16'h1234; bus_a.datai[31:16] = 16'h0F0F;
        repeat (2) @(negedge clk);
        push_exp(2'b10, 16'h1234, 16'h0F0F, 68);
        bus_a.req = 2'b10;
        @(negedge clk);
        bus_a.req = 2'b00;
        wait_done();
        repeat (4) @(negedge clk);
        chk("busy_after_pulse", 32'(bus_a.busy), 32'd0);
        chk("csb_after_pulse",  32'(bus_a.csb),  32'd1);

        // Mode and data changes during a transfer are ignored until the next grant
        bus_a.CPOL = 1'b0; bus_a.CPHA = 1'b1; slave_cpha = 1'b1;
        slave_tx = 16'h6D2B; bus_a.datai[15:0] = 16'hBEEF;
        repeat (2) @(negedge clk);
        push_exp(2'b01, 16'h6D2B, 16'hBEEF, 68);
        bus_a.req = 2'b01;
        repeat (20) @(negedge clk);
        bus_a.CPOL = 1'b1; bus_a.CPHA = 1'b0; bus_a.datai[15:0] = 16'h7E81;
        wait_done();
        bus_a.req = 2'b00;
        chk("sclk_old_cpol", 32'(bus_a.sclk), 32'd0);
        slave_cpha = 1'b0;
        repeat (4) @(negedge clk);
        chk("sclk_new_cpol_idle", 32'(bus_a.sclk), 32'd1);
        xfer0(16'h7E81, 16'h9F01, 68);
        chk("sclk_new_cpol_after", 32'(bus_a.sclk), 32'd1);

        // Reset at the 10th sclk toggle aborts; the next transfer is normal
        bus_a.CPOL = 1'b0; bus_a.CPHA = 1'b0; slave_cpha = 1'b0;
        slave_tx = 16'hFFFF; bus_a.datai[15:0] = 16'h1357;
        repeat (4) @(negedge clk);
        bus_a.req = 2'b01;
        wait_csb_low();
        for (k = 0; k < 200; k++) begin
            if (s_edges >= 10) break;
            @(negedge clk);
        end
        chk("toggle10_timeout", 32'(s_edges), 32'd10);
        resetb = 1'b0;
        bus_a.req = 2'b00;
        #1;
        chk("abort_csb",   32'(bus_a.csb),   32'd1);
        chk("abort_sclk",  32'(bus_a.sclk),  32'd0);
        chk("abort_gnt",   32'(bus_a.gnt),   32'd0);
        chk("abort_busy",  32'(bus_a.busy),  32'd0);
        chk("abort_done",  32'(bus_a.done),  32'd0);
        chk("abort_datao", 32'(bus_a.datao), 32'd0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        xfer0(16'h1357, 16'h2468, 68);

        // CLK_DIV=1 instance, CPOL=1 CPHA=0
        sel = 1'b1;
        bus_f.CPOL = 1'b1; bus_f.CPHA = 1'b0; slave_cpha = 1'b0;
        repeat (4) @(negedge clk);
        chk("fast_sclk_idle", 32'(bus_f.sclk), 32'd1);
        xfer0(16'hFFFF, 16'h8001, 34);
        chk("fast_sclk_after1", 32'(bus_f.sclk), 32'd1);
        xfer0(16'h0001, 16'h7FFE, 34);
        chk("fast_sclk_after2", 32'(bus_f.sclk), 32'd1);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
